// File: rtl/n1_pkg.sv
// Shared definitions for the N1 program-bus slice: responder FSM encoding,
// wait-state limits and the saturating probe-counter helper.
package n1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_ACK  = 2'b10
   } pbus_state_t;

   localparam int WAIT_STATES_MAX = 7;
   localparam int WAIT_CNT_W      = 3;
   localparam int PBUS_DW         = 16;

   function automatic logic [PBUS_DW-1:0] sat_inc(input logic [PBUS_DW-1:0] v);
      return (v == {PBUS_DW{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/n1_pbus_mem.sv
// Program-bus storage: one write port and one registered read port, no reset.
// A read colliding with a same-cycle write to the same word returns the new data.
module n1_pbus_mem
   import n1_pkg::*;
#(
   parameter int ADR_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADR_WIDTH-1:0] wr_adr,
   input  logic [PBUS_DW-1:0]   wr_dat,
   input  logic                 rd_en,
   input  logic [ADR_WIDTH-1:0] rd_adr,
   output logic [PBUS_DW-1:0]   rd_dat_p1
);

   logic [PBUS_DW-1:0] mem [2**ADR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_adr] <= wr_dat;
      if (rd_en)
         rd_dat_p1 <= (wr_en && (wr_adr == rd_adr)) ? wr_dat : mem[rd_adr];
   end

endmodule

// File: rtl/n1_pbus_responder.sv
// Program-bus responder: single-word memory target with programmable wait
// states, pipelined handshake and a saturating change-of-flow probe counter.
module n1_pbus_responder
   import n1_pkg::*;
#(
   parameter int ADR_WIDTH   = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic                 clk_i,
   input  logic                 async_rst_i,
   input  logic                 pbus_cyc_i,
   input  logic                 pbus_stb_i,
   input  logic                 pbus_we_i,
   input  logic [15:0]          pbus_adr_i,
   input  logic [15:0]          pbus_dat_i,
   input  logic                 pbus_tga_cof_jmp_i,
   input  logic                 pbus_tga_cof_cal_i,
   input  logic                 pbus_tga_cof_bra_i,
   input  logic                 pbus_tga_cof_eow_i,
   input  logic                 pbus_tga_dat_i,
   output logic                 pbus_ack_o,
   output logic                 pbus_stall_o,
   output logic [15:0]          pbus_dat_o,
   output logic [15:0]          prb_cof_cnt_o,
   output logic [1:0]           prb_state_o
);

   localparam int WS = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
   localparam logic [WAIT_CNT_W-1:0] WS_LOAD = (WS > 0) ? WAIT_CNT_W'(WS - 1) : '0;

   pbus_state_t           state, state_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic                  accept;
   logic                  cof_hit;
   logic [PBUS_DW-1:0]    rd_dat_p1;
   logic [PBUS_DW-1:0]    dat_hold;
   logic [PBUS_DW-1:0]    cof_cnt;
   logic                  unused_bits;

   assign accept      = pbus_cyc_i && pbus_stb_i && !pbus_stall_o;
   assign cof_hit     = pbus_tga_cof_jmp_i | pbus_tga_cof_cal_i |
                        pbus_tga_cof_bra_i | pbus_tga_cof_eow_i;
   assign unused_bits = ^{pbus_tga_dat_i, pbus_adr_i[15:ADR_WIDTH]};

   // Stage 0 -> 1: memory access at the acceptance edge
   n1_pbus_mem #(
      .ADR_WIDTH (ADR_WIDTH)
   ) u_mem (
      .clk       (clk_i),
      .wr_en     (accept && pbus_we_i),
      .wr_adr    (pbus_adr_i[ADR_WIDTH-1:0]),
      .wr_dat    (pbus_dat_i),
      .rd_en     (accept),
      .rd_adr    (pbus_adr_i[ADR_WIDTH-1:0]),
      .rd_dat_p1 (rd_dat_p1)
   );

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         cof_cnt  <= '0;
         dat_hold <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept && cof_hit)
            cof_cnt <= sat_inc(cof_cnt);
         if (state == ST_ACK)
            dat_hold <= rd_dat_p1;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      if (state == ST_WAIT) begin
         if (!pbus_cyc_i) begin
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = '0;
         end else if (wait_cnt == '0) begin
            state_nxt    = ST_ACK;
         end else begin
            wait_cnt_nxt = wait_cnt - 1'b1;
         end
      end else begin
         // IDLE and ACK both accept a fresh request; ACK otherwise retires
         state_nxt = ST_IDLE;
         if (accept) begin
            if (WS == 0) begin
               state_nxt = ST_ACK;
            end else begin
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = WS_LOAD;
            end
         end
      end
   end

   // Stage 1: response presented while in ACK, held otherwise
   assign pbus_ack_o    = (state == ST_ACK);
   assign pbus_stall_o  = (state == ST_WAIT);
   assign pbus_dat_o    = (state == ST_ACK) ? rd_dat_p1 : dat_hold;
   assign prb_cof_cnt_o = cof_cnt;
   assign prb_state_o   = state;

endmodule

// File: tb/tb_n1_pbus_responder.sv
// Directed bench for n1_pbus_responder: three instances (0, 2, 3 wait states)
// with a read-data scoreboard popped on every ack.
module tb_n1_pbus_responder;

   logic        clk = 1'b0;
   logic        async_rst = 1'b0;
   logic        cyc   [3];
   logic        stb   [3];
   logic        we    [3];
   logic [15:0] adr   [3];
   logic [15:0] wdat  [3];
   logic [4:0]  tag   [3];   // {dat, eow, bra, cal, jmp}
   logic        ack   [3];
   logic        stall [3];
   logic [15:0] rdat  [3];
   logic [15:0] cof   [3];
   logic [1:0]  st    [3];

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [15:0] q2[$];
   int          ack_cnt [3];
   int          stall0_cnt;
   int          n_assert;
   int          n_fail;

   always #5 clk = ~clk;

   n1_pbus_responder #(.ADR_WIDTH(10), .WAIT_STATES(0)) dut0 (
      .clk_i(clk), .async_rst_i(async_rst),
      .pbus_cyc_i(cyc[0]), .pbus_stb_i(stb[0]), .pbus_we_i(we[0]),
      .pbus_adr_i(adr[0]), .pbus_dat_i(wdat[0]),
      .pbus_tga_cof_jmp_i(tag[0][0]), .pbus_tga_cof_cal_i(tag[0][1]),
      .pbus_tga_cof_bra_i(tag[0][2]), .pbus_tga_cof_eow_i(tag[0][3]),
      .pbus_tga_dat_i(tag[0][4]),
      .pbus_ack_o(ack[0]), .pbus_stall_o(stall[0]), .pbus_dat_o(rdat[0]),
      .prb_cof_cnt_o(cof[0]), .prb_state_o(st[0]));

   n1_pbus_responder #(.ADR_WIDTH(10), .WAIT_STATES(2)) dut1 (
      .clk_i(clk), .async_rst_i(async_rst),
      .pbus_cyc_i(cyc[1]), .pbus_stb_i(stb[1]), .pbus_we_i(we[1]),
      .pbus_adr_i(adr[1]), .pbus_dat_i(wdat[1]),
      .pbus_tga_cof_jmp_i(tag[1][0]), .pbus_tga_cof_cal_i(tag[1][1]),
      .pbus_tga_cof_bra_i(tag[1][2]), .pbus_tga_cof_eow_i(tag[1][3]),
      .pbus_tga_dat_i(tag[1][4]),
      .pbus_ack_o(ack[1]), .pbus_stall_o(stall[1]), .pbus_dat_o(rdat[1]),
      .prb_cof_cnt_o(cof[1]), .prb_state_o(st[1]));

   n1_pbus_responder #(.ADR_WIDTH(10), .WAIT_STATES(3)) dut2 (
      .clk_i(clk), .async_rst_i(async_rst),
      .pbus_cyc_i(cyc[2]), .pbus_stb_i(stb[2]), .pbus_we_i(we[2]),
      .pbus_adr_i(adr[2]), .pbus_dat_i(wdat[2]),
      .pbus_tga_cof_jmp_i(tag[2][0]), .pbus_tga_cof_cal_i(tag[2][1]),
      .pbus_tga_cof_bra_i(tag[2][2]), .pbus_tga_cof_eow_i(tag[2][3]),
      .pbus_tga_dat_i(tag[2][4]),
      .pbus_ack_o(ack[2]), .pbus_stall_o(stall[2]), .pbus_dat_o(rdat[2]),
      .prb_cof_cnt_o(cof[2]), .prb_state_o(st[2]));

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic push(input int k, input logic [15:0] v);
      case (k)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic pop_check(input int k);
      logic [15:0] v;
      int          sz;
      sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         check($sformatf("unexpected_ack_%0d", k), 32'd1, 32'd0);
      end else begin
         case (k)
            0: v = q0.pop_front();
            1: v = q1.pop_front();
            default: v = q2.pop_front();
         endcase
         check($sformatf("ack_data_%0d", k), {16'h0, rdat[k]}, {16'h0, v});
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (ack[k] === 1'b1) begin
            ack_cnt[k]++;
            pop_check(k);
         end
      end
      if (stall[0] !== 1'b0) stall0_cnt++;
   endtask

   task automatic drive(input int k, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [4:0] t);
      cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
      adr[k] = a;    wdat[k] = d;   tag[k] = t;
   endtask

   task automatic release_bus(input int k);
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0; tag[k] = 5'b0;
   endtask

   // One complete transfer from idle: checks latency, stall count, single ack and hold
   task automatic xfer(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [4:0] t, input logic [15:0] e, input int ws);
      int a0;
      int lat;
      int stl;
      a0 = ack_cnt[k];
      push(k, e);
      drive(k, w, a, d, t);
      step();
      stb[k] = 1'b0;
      lat = 1;
      stl = 0;
      while (ack_cnt[k] == a0 && lat < 20) begin
         if (stall[k] === 1'b1) stl++;
         step();
         lat++;
      end
      check($sformatf("latency_%0d@%0h", k, a), lat, ws + 1);
      check($sformatf("stall_cycles_%0d@%0h", k, a), stl, ws);
      release_bus(k);
      step();
      check($sformatf("single_ack_%0d@%0h", k, a), ack_cnt[k] - a0, 1);
      check($sformatf("ack_low_after_%0d", k), {31'b0, ack[k]}, 0);
      check($sformatf("dat_hold_%0d", k), {16'h0, rdat[k]}, {16'h0, e});
   endtask

   initial begin
      int a0;
      n_assert = 0; n_fail = 0; stall0_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         release_bus(k);
         adr[k] = 16'h0; wdat[k] = 16'h0; ack_cnt[k] = 0;
      end

      // Asynchronous reset before any clock edge
      #1 async_rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ack_%0d", k),   {31'b0, ack[k]},   0);
         check($sformatf("rst_stall_%0d", k), {31'b0, stall[k]}, 0);
         check($sformatf("rst_state_%0d", k), {30'b0, st[k]},    0);
         check($sformatf("rst_dat_%0d", k),   {16'h0, rdat[k]},  0);
         check($sformatf("rst_cof_%0d", k),   {16'h0, cof[k]},   0);
      end
      #20 async_rst = 1'b0;

      // Zero wait states: write then read back-to-back
      push(0, 16'hBEEF);
      drive(0, 1'b1, 16'h0005, 16'hBEEF, 5'b0);
      step();
      check("b2b_ack_write", {31'b0, ack[0]}, 1);
      push(0, 16'hBEEF);
      drive(0, 1'b0, 16'h0005, 16'h0000, 5'b0);
      step();
      check("b2b_ack_read", {31'b0, ack[0]}, 1);
      release_bus(0);
      step();
      check("b2b_ack_idle", {31'b0, ack[0]}, 0);
      check("b2b_ack_count", ack_cnt[0], 2);

      // Three wait states: preload then read
      xfer(2, 1'b1, 16'h0010, 16'h1234, 5'b0, 16'h1234, 3);
      xfer(2, 1'b0, 16'h0010, 16'h0000, 5'b0, 16'h1234, 3);

      // Two wait states: cycle dropped during WAIT, write must stick
      a0 = ack_cnt[1];
      drive(1, 1'b1, 16'h0001, 16'h00AA, 5'b0);
      step();
      check("drop_stall", {31'b0, stall[1]}, 1);
      release_bus(1);
      step();
      check("drop_state_idle", {30'b0, st[1]}, 0);
      check("drop_stall_low", {31'b0, stall[1]}, 0);
      for (int i = 0; i < 4; i++) step();
      check("drop_no_ack", ack_cnt[1] - a0, 0);
      xfer(1, 1'b0, 16'h0001, 16'h0000, 5'b0, 16'h00AA, 2);

      // Reset pulse while in WAIT aborts the response
      a0 = ack_cnt[2];
      drive(2, 1'b0, 16'h0010, 16'h0000, 5'b0);
      step();
      stb[2] = 1'b0;
      step();
      check("pre_rst_stall", {31'b0, stall[2]}, 1);
      #2 async_rst = 1'b1;
      #1;
      check("rst_wait_ack",   {31'b0, ack[2]},   0);
      check("rst_wait_stall", {31'b0, stall[2]}, 0);
      check("rst_wait_state", {30'b0, st[2]},    0);
      check("rst_wait_dat",   {16'h0, rdat[2]},  0);
      #3 async_rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("rst_wait_no_ack", ack_cnt[2] - a0, 0);
      release_bus(2);
      step();
      xfer(2, 1'b0, 16'h0010, 16'h0000, 5'b0, 16'h1234, 3);

      // COF counter: cal, jmp count; dat does not
      xfer(0, 1'b0, 16'h0005, 16'h0000, 5'b00010, 16'hBEEF, 0);
      xfer(0, 1'b0, 16'h0005, 16'h0000, 5'b00001, 16'hBEEF, 0);
      xfer(0, 1'b0, 16'h0005, 16'h0000, 5'b10000, 16'hBEEF, 0);
      check("cof_count_2", {16'h0, cof[0]}, 32'd2);
      drive(0, 1'b0, 16'h0005, 16'h0000, 5'b00100);
      for (int i = 0; i < 65533; i++) begin
         push(0, 16'hBEEF);
         step();
      end
      release_bus(0);
      step();
      check("cof_count_full", {16'h0, cof[0]}, 32'hFFFF);
      xfer(0, 1'b0, 16'h0005, 16'h0000, 5'b00100, 16'hBEEF, 0);
      check("cof_count_sat", {16'h0, cof[0]}, 32'hFFFF);

      // Address aliasing above ADR_WIDTH
      xfer(0, 1'b1, 16'h0403, 16'h5A5A, 5'b0, 16'h5A5A, 0);
      xfer(0, 1'b0, 16'h0003, 16'h0000, 5'b0, 16'h5A5A, 0);

      check("stall_never_ws0", stall0_cnt, 0);
      check("queue0_empty", q0.size(), 0);
      check("queue1_empty", q1.size(), 0);
      check("queue2_empty", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
